imem_prog: RTL and testbench

- Parametrised, run-time loadable instruction memory; successor to the fixed-ROM fetch memory.
- Synchronous 1-cycle read on the fetch side.
- A host/loader streams a program in through a valid/ready port, with an auto-incrementing write pointer; unwritten tail words are then padded with NOP.
- Sits between the fetch stage (PC → addr) and a loader (UART/debug bridge), so programs change without re-synthesis.

---
 rtl/imem_pkg.sv | 12 +
 rtl/imem_ram.sv | 28 ++
 rtl/imem_prog.sv | 130 +++++++++++++
 tb/tb_imem_prog.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the loadable instruction memory
package imem_pkg;

  localparam logic [31:0] NOP = 32'h8b1f03ff;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LOAD = 2'd1,
    PAD  = 2'd2
  } imem_state_t;

endpackage

// File: rtl/imem_ram.sv
// rtl/imem_ram.sv - single-port DEPTH x N array, synchronous write and read, powers up as FILL
module imem_ram #(
  parameter int          N      = 32,
  parameter int          ADDR_W = 7,
  parameter logic [N-1:0] FILL  = 32'h8b1f03ff
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [N-1:0]      wdata,
  output logic [N-1:0]      rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [N-1:0] mem [DEPTH] = '{default: FILL};
  logic [N-1:0] rdata_q;

  // No reset on the array or read register: contents survive a reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/imem_prog.sv
// rtl/imem_prog.sv - run-time loadable instruction memory: 1-cycle fetch, streamed load, NOP tail pad
module imem_prog
  import imem_pkg::*;
#(
  parameter int           N      = 32,
  parameter int           ADDR_W = 7,
  parameter logic [N-1:0] FILL   = N'(NOP)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd_en,
  output logic [N-1:0]      q,
  output logic              q_valid,
  input  logic              prog_start,
  input  logic              prog_valid,
  input  logic [N-1:0]      prog_data,
  input  logic              prog_last,
  output logic              prog_ready,
  output logic              busy,
  output logic              prog_done,
  output logic [ADDR_W:0]   prog_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  imem_state_t       state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   prog_count_q, prog_count_d;
  logic              q_valid_q, q_valid_d;
  logic              prog_done_q, prog_done_d;
  logic              fill_q, fill_d;

  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [N-1:0]      ram_wdata, ram_rdata;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    prog_count_d = prog_count_q;
    q_valid_d    = 1'b0;
    prog_done_d  = 1'b0;
    fill_d       = fill_q;
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    ram_addr     = addr;
    ram_wdata    = prog_data;
    unique case (state_q)
      RUN: begin
        if (prog_start) begin
          state_d      = LOAD;
          wr_ptr_d     = '0;
          prog_count_d = '0;
          fill_d       = 1'b1;
        end else if (rd_en) begin
          ram_re    = 1'b1;
          q_valid_d = 1'b1;
          fill_d    = 1'b0;
        end
      end
      LOAD: begin
        ram_addr = wr_ptr_q;
        if (prog_valid) begin
          ram_we       = 1'b1;
          wr_ptr_d     = wr_ptr_q + ADDR_W'(1);
          prog_count_d = prog_count_q + (ADDR_W + 1)'(1);
          // A full array ends the load even without prog_last; nothing left to pad.
          if (wr_ptr_q == LAST_ADDR) begin
            state_d     = RUN;
            prog_done_d = 1'b1;
          end else if (prog_last) begin
            state_d = PAD;
          end
        end
      end
      PAD: begin
        ram_addr  = wr_ptr_q;
        ram_we    = 1'b1;
        ram_wdata = FILL;
        wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
        if (wr_ptr_q == LAST_ADDR) begin
          state_d     = RUN;
          prog_done_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= RUN;
      wr_ptr_q     <= '0;
      prog_count_q <= '0;
      q_valid_q    <= 1'b0;
      prog_done_q  <= 1'b0;
      fill_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      prog_count_q <= prog_count_d;
      q_valid_q    <= q_valid_d;
      prog_done_q  <= prog_done_d;
      fill_q       <= fill_d;
    end
  end

  imem_ram #(
    .N      (N),
    .ADDR_W (ADDR_W),
    .FILL   (FILL)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // fill_q masks the RAM read register until the first fetch after reset or a load.
  assign q          = fill_q ? FILL : ram_rdata;
  assign q_valid    = q_valid_q;
  assign prog_ready = (state_q == LOAD);
  assign busy       = (state_q != RUN);
  assign prog_done  = prog_done_q;
  assign prog_count = prog_count_q;

endmodule

// File: tb/tb_imem_prog.sv
// tb/tb_imem_prog.sv - randomized self-checking bench for imem_prog against an array model
module tb_imem_prog;

  localparam int          N      = 32;
  localparam int          ADDR_W = 7;
  localparam int          DEPTH  = 128;
  localparam logic [31:0] NOP_W  = 32'h8b1f03ff;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] addr;
  logic              rd_en;
  logic [N-1:0]      q;
  logic              q_valid;
  logic              prog_start;
  logic              prog_valid;
  logic [N-1:0]      prog_data;
  logic              prog_last;
  logic              prog_ready;
  logic              busy;
  logic              prog_done;
  logic [ADDR_W:0]   prog_count;

  imem_prog #(.N(N), .ADDR_W(ADDR_W), .FILL(NOP_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .rd_en      (rd_en),
    .q          (q),
    .q_valid    (q_valid),
    .prog_start (prog_start),
    .prog_valid (prog_valid),
    .prog_data  (prog_data),
    .prog_last  (prog_last),
    .prog_ready (prog_ready),
    .busy       (busy),
    .prog_done  (prog_done),
    .prog_count (prog_count)
  );

  always #5 clk = ~clk;

  logic [31:0] model [DEPTH];
  logic [31:0] words [$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_one(input int a);
    addr  = ADDR_W'(a);
    rd_en = 1'b1;
    step();
    check("rd_valid", q_valid, 1);
    check($sformatf("rd_q[%0d]", a), q, model[a]);
  endtask

  task automatic read_random(input int n);
    for (int k = 0; k < n; k++) read_one($urandom_range(0, DEPTH - 1));
    rd_en = 1'b0;
  endtask

  // Streams the queued words; the model is updated per accepted word, tail padded to NOP.
  task automatic do_load(input bit gappy, input bit hold, input bit rd_first);
    int nw;
    int pad;
    int done_cnt;
    int stalls;
    nw         = words.size();
    prog_start = 1'b1;
    rd_en      = hold | rd_first;
    addr       = ADDR_W'($urandom);
    step();
    if (!hold) begin
      prog_start = 1'b0;
      rd_en      = 1'b0;
    end
    check("ld_busy", busy, 1);
    check("ld_ready", prog_ready, 1);
    check("ld_cnt0", prog_count, 0);
    check("ld_qv", q_valid, 0);
    for (int i = 0; i < nw; i++) begin
      stalls = 0;
      while (gappy && stalls < 4 && $urandom_range(0, 2) == 0) begin
        prog_valid = 1'b0;
        prog_last  = 1'($urandom);
        prog_data  = $urandom;
        step();
        stalls++;
        check("stall_cnt", prog_count, i);
        check("stall_qv", q_valid, 0);
        check("stall_q", q, NOP_W);
        check("stall_ready", prog_ready, 1);
      end
      prog_valid = 1'b1;
      prog_data  = words[i];
      prog_last  = (i == nw - 1);
      step();
      model[i] = words[i];
      if (hold && i == nw - 1) begin
        prog_start = 1'b0;
        rd_en      = 1'b0;
      end
      prog_valid = 1'b0;
      prog_last  = 1'b0;
      check("acc_cnt", prog_count, i + 1);
    end
    check("end_ready", prog_ready, 0);
    for (int j = nw; j < DEPTH; j++) model[j] = NOP_W;
    pad      = 0;
    done_cnt = 0;
    while (busy && pad < 300) begin
      if (prog_done) done_cnt++;
      step();
      pad++;
    end
    check("pad_cycles", pad, DEPTH - nw);
    check("done_early", done_cnt, 0);
    check("done_pulse", prog_done, 1);
    step();
    check("done_clear", prog_done, 0);
    check("final_cnt", prog_count, nw);
  endtask

  task automatic fill_words(input int n);
    words.delete();
    for (int k = 0; k < n; k++) words.push_back($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = NOP_W;
    reset      = 1'b0;
    addr       = '0;
    rd_en      = 1'b0;
    prog_start = 1'b0;
    prog_valid = 1'b0;
    prog_data  = '0;
    prog_last  = 1'b0;
    step();
    step();
    check("rst_q", q, NOP_W);
    check("rst_qv", q_valid, 0);
    check("rst_ready", prog_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", prog_done, 0);
    check("rst_cnt", prog_count, 0);
    reset = 1'b1;
    step();

    for (int a = 0; a < DEPTH; a++) read_one(a);
    rd_en = 1'b0;
    step();
    check("idle_qv", q_valid, 0);
    check("idle_hold", q, model[DEPTH - 1]);

    words.delete();
    words.push_back(32'h8b0103e4);
    words.push_back(32'h8b1f03e0);
    words.push_back(32'hf8000003);
    do_load(1'b0, 1'b0, 1'b0);
    for (int a = 0; a < 4; a++) read_one(a);
    rd_en = 1'b0;

    fill_words(DEPTH);
    do_load(1'b1, 1'b0, 1'b0);
    read_one(DEPTH - 1);
    read_one(0);
    read_random(48);

    // Reset mid-load: 5 of 10 words land, the rest keep the previous load.
    fill_words(10);
    prog_start = 1'b1;
    step();
    prog_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      prog_valid = 1'b1;
      prog_data  = words[i];
      step();
      model[i] = words[i];
    end
    prog_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", prog_ready, 0);
    check("mid_rst_done", prog_done, 0);
    check("mid_rst_cnt", prog_count, 0);
    check("mid_rst_q", q, NOP_W);
    step();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("post_rst_done", prog_done, 0);
      check("post_rst_busy", busy, 0);
    end
    for (int a = 0; a < 10; a++) read_one(a);
    rd_en = 1'b0;

    fill_words(10);
    do_load(1'b1, 1'b1, 1'b0);
    read_random(24);

    fill_words(1);
    do_load(1'b0, 1'b0, 1'b1);
    read_one(0);
    read_one(1);
    read_one(DEPTH - 1);
    rd_en = 1'b0;

    for (int r = 0; r < 3; r++) begin
      fill_words($urandom_range(1, DEPTH));
      do_load(1'($urandom), 1'b0, 1'($urandom));
      read_random(32);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
